avalon_bus_arbiter: RTL and testbench
=====================================

AVALON_BUS_ARBITER -- requirements
Module: avalon_bus_arbiter

Interface
REQ-001 The block SHALL have parameter OUTSTANDING, default 4, meaning the maximum number of accepted reads awaiting readdatavalid (legal values 1..8).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset is asynchronous and active-low (0 = reset).
REQ-004 The block SHALL have port h0_avalon_req, input, avalon_req_t, host 0 (instruction bus) request: read, write, address[31:0], writedata[31:0], byte_enable[3:0].
REQ-005 The block SHALL have port h0_avalon_resp, output, avalon_resp_t, host 0 response: readdata[31:0], readdatavalid, waitrequest.
REQ-006 The block SHALL have port h1_avalon_req, input, avalon_req_t, host 1 (data bus, from MEM/lsu) request.
REQ-007 The block SHALL have port h1_avalon_resp, output, avalon_resp_t, host 1 response.
REQ-008 The block SHALL have port dev_avalon_req, output, avalon_req_t, request to the shared memory device.
REQ-009 The block SHALL have port dev_avalon_resp, input, avalon_resp_t, response from the shared device.
REQ-010 The block SHALL have port pending_count, output, 4, the number of reads outstanding.
REQ-011 The block SHALL have port rsp_error, output, 1, sticky flag for a readdatavalid received with no read outstanding.

Function
REQ-012 The block SHALL treat a host as requesting when read|write=1; read and write both asserted is illegal and SHALL be forwarded unchanged.
REQ-013 Arbitration, when unlocked, SHALL be combinational (zero-cycle): one requester -> that host; both -> the host not equal to last_served.
REQ-014 last_served SHALL reset to 1, so host 0 wins the first contention, and SHALL update to the granted host on each cycle a command is accepted (dev read|write=1 and waitrequest=0).
REQ-015 dev_avalon_req SHALL equal the granted host's request; with no requester it SHALL drive read=0 and write=0, with other fields don't-care.
REQ-016 Lock: once dev read|write=1 with dev waitrequest=1, the grant SHALL be held on the following cycles until that command is accepted (Avalon stability rule); the other host cannot preempt it.
REQ-017 The granted host's waitrequest SHALL equal dev waitrequest; the non-granted or idle host SHALL see waitrequest=1 while requesting.
REQ-018 A tag FIFO of depth OUTSTANDING SHALL record the owner ID (0/1) of every accepted read; writes are not recorded.
REQ-019 If the FIFO is full, a granted read SHALL be suppressed: dev read=0 and host waitrequest=1, even if a pop occurs in the same cycle. A granted write SHALL proceed.
REQ-020 Each dev readdatavalid=1 SHALL pop the FIFO head and assert readdatavalid only on the owner's response port in the same cycle; readdata SHALL be broadcast to both hosts.
REQ-021 A simultaneous push and pop SHALL leave pending_count unchanged and preserve FIFO order, including when empty (pop-less passthrough not allowed: the pop targets the pre-existing head).
REQ-022 readdatavalid with pending_count=0 SHALL be dropped (no host readdatavalid) and SHALL set rsp_error until reset.
REQ-023 FIFO pointers SHALL wrap modulo OUTSTANDING; pending_count SHALL never exceed OUTSTANDING.
REQ-024 The arbiter SHALL allow host B's command to issue while host A's reads are still outstanding; responses SHALL return in issue order.

Reset
REQ-025 While rst=0 the block SHALL force dev read=0, dev write=0, host waitrequest=1, host readdatavalid=0, pending_count=0, rsp_error=0, lock=0, last_served=1, and FIFO pointers=0.
REQ-026 Reset asserted mid-transaction SHALL discard outstanding tags; device responses arriving after reset SHALL be handled per REQ-022.
REQ-027 The first grant SHALL be possible in the first cycle after rst rises.

Verification
REQ-028 Contention: h0 and h1 read in the same cycle with waitrequest=0 -> h0 granted in cycle 0, h1 in cycle 1, pending_count=2; responses route to h0, then h1.
REQ-029 Lock: h1 write with dev waitrequest=1 for 3 cycles while h0 also requests -> dev_avalon_req stays h1 for all 3 cycles; h0 granted in the cycle after acceptance.
REQ-030 Full: OUTSTANDING=4, 4 reads accepted with no response -> 5th read sees waitrequest=1 and dev read=0; a write from the other host is still accepted.
REQ-031 Push and pop together at pending_count=2 -> count stays 2; readdatavalid goes to the older owner.
REQ-032 Spurious response: readdatavalid with count=0 -> no host readdatavalid, rsp_error=1 until reset.
REQ-033 Async reset with 3 reads pending -> count=0 immediately and host waitrequest=1 without a clock edge.

Source files
------------

// File: rtl/avalon_bus_arbiter.sv
// Two-host Avalon-MM arbiter in front of one shared memory device.
// Round-robin grant with a stability lock, plus a tag FIFO that routes read responses.

package avalon_pkg;
  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byte_enable;
  } avalon_req_t;

  typedef struct packed {
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;
  } avalon_resp_t;
endpackage

module avalon_bus_arbiter
  import avalon_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  avalon_req_t  h0_avalon_req,
  output avalon_resp_t h0_avalon_resp,
  input  avalon_req_t  h1_avalon_req,
  output avalon_resp_t h1_avalon_resp,
  output avalon_req_t  dev_avalon_req,
  input  avalon_resp_t dev_avalon_resp,
  output logic [3:0]   pending_count,
  output logic         rsp_error
);

  localparam logic [3:0] MaxCnt  = 4'(OUTSTANDING);
  localparam logic [2:0] LastPtr = 3'(OUTSTANDING - 1);

  logic       lock_q, lock_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [3:0] count_q, count_d;
  logic [2:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] rd_ptr_q, rd_ptr_d;
  logic [7:0] tags_q, tags_d;
  logic       err_q, err_d;

  logic        h0_rq, h1_rq, any_rq, grant, blocked, dev_cmd, accept, push, pop, head;
  avalon_req_t sel_req;

  always_comb begin
    h0_rq  = h0_avalon_req.read | h0_avalon_req.write;
    h1_rq  = h1_avalon_req.read | h1_avalon_req.write;
    any_rq = lock_q | h0_rq | h1_rq;

    if (lock_q) begin
      grant = owner_q;
    end else if (h0_rq && h1_rq) begin
      grant = ~last_q;
    end else begin
      grant = h1_rq;
    end

    sel_req = grant ? h1_avalon_req : h0_avalon_req;
    // A full tag FIFO stalls the read even if a pop lands this same cycle.
    blocked = sel_req.read && (count_q == MaxCnt);

    dev_avalon_req = sel_req;
    if (!any_rq || blocked || !rst) begin
      dev_avalon_req.read  = 1'b0;
      dev_avalon_req.write = 1'b0;
    end

    dev_cmd = dev_avalon_req.read | dev_avalon_req.write;
    accept  = dev_cmd & ~dev_avalon_resp.waitrequest;
    push    = accept & dev_avalon_req.read;
    pop     = dev_avalon_resp.readdatavalid && (count_q != 4'd0);
    head    = tags_q[rd_ptr_q];

    h0_avalon_resp.readdata      = dev_avalon_resp.readdata;
    h1_avalon_resp.readdata      = dev_avalon_resp.readdata;
    h0_avalon_resp.readdatavalid = rst & pop & ~head;
    h1_avalon_resp.readdatavalid = rst & pop & head;
    h0_avalon_resp.waitrequest   = 1'b1;
    h1_avalon_resp.waitrequest   = 1'b1;
    if (rst && any_rq) begin
      if (grant) h1_avalon_resp.waitrequest = blocked | dev_avalon_resp.waitrequest;
      else       h0_avalon_resp.waitrequest = blocked | dev_avalon_resp.waitrequest;
    end

    // Hold the grant while the device stalls a presented command.
    lock_d  = dev_cmd & dev_avalon_resp.waitrequest;
    owner_d = grant;
    last_d  = accept ? grant : last_q;

    tags_d   = tags_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      tags_d[wr_ptr_q] = grant;
      wr_ptr_d = (wr_ptr_q == LastPtr) ? 3'd0 : wr_ptr_q + 3'd1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? 3'd0 : rd_ptr_q + 3'd1;
    end
    count_d = count_q + {3'b000, push} - {3'b000, pop};
    err_d   = err_q | (dev_avalon_resp.readdatavalid && (count_q == 4'd0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q   <= 1'b0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      count_q  <= 4'd0;
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      tags_q   <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      lock_q   <= lock_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tags_q   <= tags_d;
      err_q    <= err_d;
    end
  end

  assign pending_count = count_q;
  assign rsp_error     = err_q;

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed bench for avalon_bus_arbiter; read responses are checked by a scoreboard monitor.

module tb_avalon_bus_arbiter;
  import avalon_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  avalon_req_t  h0_req, h1_req, dev_req;
  avalon_resp_t h0_resp, h1_resp, dev_resp;
  logic [3:0]   pending_count;
  logic         rsp_error;

  avalon_bus_arbiter #(.OUTSTANDING(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .h0_avalon_req  (h0_req),
    .h0_avalon_resp (h0_resp),
    .h1_avalon_req  (h1_req),
    .h1_avalon_resp (h1_resp),
    .dev_avalon_req (dev_req),
    .dev_avalon_resp(dev_resp),
    .pending_count  (pending_count),
    .rsp_error      (rsp_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          host;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_h(input int h, input logic rd, input logic wr, input logic [31:0] addr);
    avalon_req_t r;
    r             = '0;
    r.read        = rd;
    r.write       = wr;
    r.address     = addr;
    r.writedata   = ~addr;
    r.byte_enable = 4'hf;
    if (h == 0) h0_req = r;
    else        h1_req = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    dev_resp.readdatavalid = 1'b0;
    dev_resp.readdata      = '0;
  endtask

  task automatic respond(input logic [31:0] data, input bit host);
    exp_t e;
    e.host = host;
    e.data = data;
    sb_q.push_back(e);
    dev_resp.readdatavalid = 1'b1;
    dev_resp.readdata      = data;
  endtask

  // Response monitor: every host readdatavalid must match the oldest expected response.
  always @(negedge clk) begin
    if (rst && (h0_resp.readdatavalid || h1_resp.readdatavalid)) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rdv_unexpected: got h0=%b h1=%b expected no readdatavalid at %0t",
                 h0_resp.readdatavalid, h1_resp.readdatavalid, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk1("rdv_onehot", h0_resp.readdatavalid & h1_resp.readdatavalid, 1'b0);
        chk1("rdv_host", h1_resp.readdatavalid, e.host);
        chk32("rdv_data", e.host ? h1_resp.readdata : h0_resp.readdata, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    h0_req = '0;
    h1_req = '0;
    dev_resp = '0;
    repeat (2) @(posedge clk);
    #1;
    set_h(0, 1'b1, 1'b0, 32'h10);
    #1;
    chk1("rst_h0_wait", h0_resp.waitrequest, 1'b1);
    chk1("rst_dev_rd", dev_req.read, 1'b0);
    chk32("rst_cnt", 32'(pending_count), 32'd0);
    chk1("rst_err", rsp_error, 1'b0);
    set_h(0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;

    // Contention: h0 wins first (last_served resets to 1), then h1.
    tick();
    set_h(0, 1'b1, 1'b0, 32'h100);
    set_h(1, 1'b1, 1'b0, 32'h200);
    #1;
    chk32("cont_c0_addr", dev_req.address, 32'h100);
    chk1("cont_c0_h0_wait", h0_resp.waitrequest, 1'b0);
    chk1("cont_c0_h1_wait", h1_resp.waitrequest, 1'b1);
    tick();
    set_h(0, 1'b0, 1'b0, 32'h0);
    #1;
    chk32("cont_c1_addr", dev_req.address, 32'h200);
    chk1("cont_c1_h1_wait", h1_resp.waitrequest, 1'b0);
    tick();
    set_h(1, 1'b0, 1'b0, 32'h0);
    #1;
    chk32("cont_cnt", 32'(pending_count), 32'd2);
    chk1("idle_dev_rd", dev_req.read, 1'b0);
    respond(32'hA000_0001, 1'b0);
    #1;
    chk32("bcast_data", h1_resp.readdata, 32'hA000_0001);
    chk1("bcast_h1_rdv", h1_resp.readdatavalid, 1'b0);
    tick();
    respond(32'hA000_0002, 1'b1);
    tick();
    #1;
    chk32("cont_drain", 32'(pending_count), 32'd0);

    // Lock: h1 write stalled for 3 cycles, h0 joins and must not preempt.
    dev_resp.waitrequest = 1'b1;
    set_h(1, 1'b0, 1'b1, 32'h300);
    #1;
    chk32("lock_c0_addr", dev_req.address, 32'h300);
    chk1("lock_c0_h1_wait", h1_resp.waitrequest, 1'b1);
    tick();
    set_h(0, 1'b1, 1'b0, 32'h400);
    #1;
    chk32("lock_c1_addr", dev_req.address, 32'h300);
    chk1("lock_c1_h0_wait", h0_resp.waitrequest, 1'b1);
    tick();
    #1;
    chk32("lock_c2_addr", dev_req.address, 32'h300);
    tick();
    dev_resp.waitrequest = 1'b0;
    #1;
    chk32("lock_acc_addr", dev_req.address, 32'h300);
    chk1("lock_acc_wr", dev_req.write, 1'b1);
    chk1("lock_acc_h1_wait", h1_resp.waitrequest, 1'b0);
    tick();
    set_h(1, 1'b0, 1'b0, 32'h0);
    #1;
    chk32("lock_after_addr", dev_req.address, 32'h400);
    chk1("lock_after_h0_wait", h0_resp.waitrequest, 1'b0);
    tick();
    set_h(0, 1'b0, 1'b0, 32'h0);
    respond(32'hB000_0001, 1'b0);
    tick();

    // Full: 4 reads outstanding, 5th read stalled, write from h1 still goes through.
    for (int i = 0; i < 4; i++) begin
      set_h(0, 1'b1, 1'b0, 32'h500 + 32'(i * 4));
      #1;
      chk1("fill_dev_rd", dev_req.read, 1'b1);
      tick();
    end
    #1;
    chk32("full_cnt", 32'(pending_count), 32'd4);
    chk1("full_dev_rd", dev_req.read, 1'b0);
    chk1("full_h0_wait", h0_resp.waitrequest, 1'b1);
    tick();
    set_h(0, 1'b0, 1'b0, 32'h0);
    set_h(1, 1'b0, 1'b1, 32'h600);
    #1;
    chk1("full_wr", dev_req.write, 1'b1);
    chk1("full_wr_h1_wait", h1_resp.waitrequest, 1'b0);
    tick();
    set_h(1, 1'b0, 1'b0, 32'h0);
    set_h(0, 1'b1, 1'b0, 32'h700);
    respond(32'hC000_0001, 1'b0);
    #1;
    chk1("full_pop_dev_rd", dev_req.read, 1'b0);
    chk1("full_pop_h0_wait", h0_resp.waitrequest, 1'b1);
    tick();
    set_h(0, 1'b0, 1'b0, 32'h0);
    #1;
    chk32("full_pop_cnt", 32'(pending_count), 32'd3);
    respond(32'hC000_0002, 1'b0);
    tick();

    // Push and pop together at count 2: order preserved, count unchanged.
    set_h(1, 1'b1, 1'b0, 32'h800);
    respond(32'hC000_0003, 1'b0);
    #1;
    chk1("pp_h1_wait", h1_resp.waitrequest, 1'b0);
    tick();
    set_h(1, 1'b0, 1'b0, 32'h0);
    #1;
    chk32("pp_cnt", 32'(pending_count), 32'd2);
    respond(32'hC000_0004, 1'b0);
    tick();
    respond(32'hC000_0005, 1'b1);
    tick();
    #1;
    chk32("pp_drain", 32'(pending_count), 32'd0);

    // Spurious response with nothing outstanding.
    dev_resp.readdatavalid = 1'b1;
    dev_resp.readdata      = 32'hDEAD_BEEF;
    #1;
    chk1("spur_h0_rdv", h0_resp.readdatavalid, 1'b0);
    chk1("spur_h1_rdv", h1_resp.readdatavalid, 1'b0);
    tick();
    #1;
    chk1("spur_err", rsp_error, 1'b1);
    tick();
    tick();
    #1;
    chk1("spur_err_sticky", rsp_error, 1'b1);

    // Async reset with 3 reads pending.
    set_h(0, 1'b1, 1'b0, 32'h900);
    tick();
    tick();
    tick();
    #1;
    chk32("pre_rst_cnt", 32'(pending_count), 32'd3);
    #1;
    rst = 1'b0;
    #1;
    chk32("arst_cnt", 32'(pending_count), 32'd0);
    chk1("arst_h0_wait", h0_resp.waitrequest, 1'b1);
    chk1("arst_dev_rd", dev_req.read, 1'b0);
    chk1("arst_err", rsp_error, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk1("first_grant_dev_rd", dev_req.read, 1'b1);
    chk1("first_grant_h0_wait", h0_resp.waitrequest, 1'b0);
    tick();
    set_h(0, 1'b0, 1'b0, 32'h0);
    respond(32'hD000_0001, 1'b0);
    tick();
    #1;
    chk32("post_rst_cnt", 32'(pending_count), 32'd0);
    // Response for a tag discarded by reset.
    dev_resp.readdatavalid = 1'b1;
    dev_resp.readdata      = 32'hD000_0002;
    #1;
    chk1("late_h0_rdv", h0_resp.readdatavalid, 1'b0);
    tick();
    #1;
    chk1("late_err", rsp_error, 1'b1);

    tick();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_empty: got %0d pending responses expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
